// File: rtl/exe_div_seq_pkg.sv
// Shared types for the execute-stage iterative divider: operation codes,
// FSM states and the EXE<->divider port bundles.
package exe_div_seq_pkg;

   localparam int DIV_XLEN = 32;

   typedef enum logic [1:0] {
      DIV_OPS_DIV  = 2'b00,
      DIV_OPS_DIVU = 2'b01,
      DIV_OPS_REM  = 2'b10,
      DIV_OPS_REMU = 2'b11
   } type_div_ops_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_CALC = 2'b01,
      DIV_DONE = 2'b10
   } type_div_state_e;

   typedef struct packed {
      logic                div_req;
      type_div_ops_e       div_ops;
      logic [DIV_XLEN-1:0] div_opr1;
      logic [DIV_XLEN-1:0] div_opr2;
      logic                div_kill;
   } type_exe2div_s;

   typedef struct packed {
      logic                div_stall;
      logic                div_valid;
      logic [DIV_XLEN-1:0] div_result;
      logic                div_busy;
   } type_div2exe_s;

   function automatic logic div_is_signed(input type_div_ops_e ops);
      return (ops == DIV_OPS_DIV) || (ops == DIV_OPS_REM);
   endfunction

   function automatic logic div_is_rem(input type_div_ops_e ops);
      return (ops == DIV_OPS_REM) || (ops == DIV_OPS_REMU);
   endfunction

endpackage

// File: rtl/exe_div_seq.sv
// Restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU. Stalls EXE while it
// iterates one quotient bit per cycle and returns the result with a valid pulse.
module exe_div_seq
   import exe_div_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_req_i,
   input  logic [1:0]      div_ops_i,
   input  logic [XLEN-1:0] div_opr1_i,
   input  logic [XLEN-1:0] div_opr2_i,
   input  logic            div_kill_i,
   output logic            div_stall_o,
   output logic            div_valid_o,
   output logic [XLEN-1:0] div_result_o,
   output logic            div_busy_o
);

   localparam int              CNT_W    = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   type_div_state_e state;
   type_div_ops_e   ops_q;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvs_q;
   logic             neg_q;
   logic             neg_r;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

   // Request decode: operand signs, magnitudes and the two RISC-V corner cases.
   type_div_ops_e   req_ops;
   logic            req_signed;
   logic            sign1;
   logic            sign2;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] special_res;

   assign req_ops    = type_div_ops_e'(div_ops_i);
   assign req_signed = div_is_signed(req_ops);
   assign sign1      = req_signed & div_opr1_i[XLEN-1];
   assign sign2      = req_signed & div_opr2_i[XLEN-1];
   assign div_zero   = (div_opr2_i == '0);
   assign div_ovf    = req_signed & (div_opr1_i == INT_MIN) & (div_opr2_i == '1);

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = div_is_rem(req_ops) ? div_opr1_i : '1;
      end else begin
         special_res = div_is_rem(req_ops) ? '0 : div_opr1_i;
      end
   end

   // One restoring step; the partial remainder needs XLEN+1 bits after the shift.
   logic [XLEN:0]        rem_sh;
   logic signed [XLEN:0] diff;
   logic                 q_bit;
   logic [XLEN-1:0]      rem_nx;
   logic [XLEN-1:0]      quo_nx;
   logic [XLEN-1:0]      final_res;

   assign rem_sh    = {rem_q, quo_q[XLEN-1]};
   assign diff      = $signed(rem_sh - {1'b0, dvs_q});
   assign q_bit     = ~diff[XLEN];
   assign rem_nx    = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_nx    = {quo_q[XLEN-2:0], q_bit};
   assign final_res = div_is_rem(ops_q) ? neg_if(rem_nx, neg_r) : neg_if(quo_nx, neg_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= DIV_IDLE;
         ops_q        <= DIV_OPS_DIV;
         cnt          <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         dvs_q        <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         div_valid_o  <= 1'b0;
         div_result_o <= '0;
      end else begin
         div_valid_o <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (div_req_i && !div_kill_i) begin
                  ops_q <= req_ops;
                  neg_q <= sign1 ^ sign2;
                  neg_r <= sign1;
                  cnt   <= CNT_INIT;
                  rem_q <= '0;
                  quo_q <= neg_if(div_opr1_i, sign1);
                  dvs_q <= neg_if(div_opr2_i, sign2);
                  if (div_zero || div_ovf) begin
                     div_result_o <= special_res;
                     div_valid_o  <= 1'b1;
                     state        <= DIV_DONE;
                  end else begin
                     state <= DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               if (div_kill_i) begin
                  cnt   <= '0;
                  state <= DIV_IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt   <= cnt - CNT_LAST;
                  if (cnt == CNT_LAST) begin
                     div_result_o <= final_res;
                     div_valid_o  <= 1'b1;
                     state        <= DIV_DONE;
                  end
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

   assign div_stall_o = div_req_i & ~div_kill_i & (state != DIV_DONE);
   assign div_busy_o  = (state != DIV_IDLE);

endmodule

// File: tb/tb_exe_div_seq.sv
// Directed bench for exe_div_seq: expected results are queued at request time
// and popped when the divider pulses valid.
module tb_exe_div_seq;
   import exe_div_seq_pkg::*;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst;
   logic            div_req_i;
   logic [1:0]      div_ops_i;
   logic [XLEN-1:0] div_opr1_i;
   logic [XLEN-1:0] div_opr2_i;
   logic            div_kill_i;
   logic            div_stall_o;
   logic            div_valid_o;
   logic [XLEN-1:0] div_result_o;
   logic            div_busy_o;

   int checks = 0;
   int errors = 0;
   logic [XLEN-1:0] exp_q[$];

   exe_div_seq #(.XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .div_req_i    (div_req_i),
      .div_ops_i    (div_ops_i),
      .div_opr1_i   (div_opr1_i),
      .div_opr2_i   (div_opr2_i),
      .div_kill_i   (div_kill_i),
      .div_stall_o  (div_stall_o),
      .div_valid_o  (div_valid_o),
      .div_result_o (div_result_o),
      .div_busy_o   (div_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives a request at the start of a cycle (cycle 0 of the operation).
   task automatic start_op(input type_div_ops_e ops, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b);
      @(posedge clk);
      #1;
      div_req_i  = 1'b1;
      div_ops_i  = ops;
      div_opr1_i = a;
      div_opr2_i = b;
      div_kill_i = 1'b0;
   endtask

   // Issues one operation and checks result, latency and stall length.
   // Returns at the DONE cycle with the request still held high.
   task automatic do_op(input string tag, input type_div_ops_e ops, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
      int cyc;
      int stall_cnt;
      logic got;
      logic [XLEN-1:0] want;
      start_op(ops, a, b);
      exp_q.push_back(exp);
      cyc = 0;
      stall_cnt = 0;
      got = 1'b0;
      while (!got && cyc <= lat + 4) begin
         @(negedge clk);
         if (div_stall_o) stall_cnt++;
         if (div_valid_o) begin
            got = 1'b1;
            want = exp_q.pop_front();
            check({tag, "_result"}, div_result_o, want);
            check({tag, "_latency"}, XLEN'(cyc), XLEN'(lat));
            check({tag, "_stall_done"}, XLEN'(div_stall_o), '0);
         end else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      check({tag, "_timeout"}, XLEN'(got), XLEN'(1));
      check({tag, "_stall_cycles"}, XLEN'(stall_cnt), XLEN'(lat));
      if (!got) exp_q.delete();
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      div_req_i  = 1'b0;
      div_kill_i = 1'b0;
   endtask

   initial begin
      logic saw_valid;
      rst        = 1'b1;
      div_req_i  = 1'b0;
      div_ops_i  = 2'b00;
      div_opr1_i = '0;
      div_opr2_i = '0;
      div_kill_i = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_valid", XLEN'(div_valid_o), '0);
      check("rst_result", div_result_o, '0);
      check("rst_busy", XLEN'(div_busy_o), '0);
      check("rst_stall", XLEN'(div_stall_o), '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Normal unsigned and signed operations.
      do_op("divu_100_7", DIV_OPS_DIVU, 32'd100, 32'd7, 32'd14, 33);
      go_idle();
      do_op("remu_100_7", DIV_OPS_REMU, 32'd100, 32'd7, 32'd2, 33);
      go_idle();
      do_op("div_m100_7", DIV_OPS_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
      go_idle();
      do_op("rem_m100_7", DIV_OPS_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
      go_idle();
      do_op("div_7_m2", DIV_OPS_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      go_idle();
      do_op("rem_7_m2", DIV_OPS_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      go_idle();

      // Divide-by-zero and signed overflow resolve in one cycle.
      do_op("divu_5_0", DIV_OPS_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      go_idle();
      do_op("remu_5_0", DIV_OPS_REMU, 32'd5, 32'd0, 32'd5, 1);
      go_idle();
      do_op("div_m3_0", DIV_OPS_DIV, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, 1);
      go_idle();
      do_op("rem_m3_0", DIV_OPS_REM, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFD, 1);
      go_idle();
      do_op("div_ovf", DIV_OPS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      go_idle();
      do_op("rem_ovf", DIV_OPS_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      go_idle();

      // Kill in cycle 10 of a running DIVU.
      saw_valid = 1'b0;
      start_op(DIV_OPS_DIVU, 32'd1000, 32'd3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (div_valid_o) saw_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      div_kill_i = 1'b1;
      @(negedge clk);
      check("kill_stall_drop", XLEN'(div_stall_o), '0);
      @(posedge clk);
      #1;
      div_kill_i = 1'b0;
      div_req_i  = 1'b0;
      @(negedge clk);
      check("kill_idle", XLEN'(div_busy_o), '0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (div_valid_o) saw_valid = 1'b1;
      end
      check("kill_no_valid", XLEN'(saw_valid), '0);
      do_op("divu_20_3", DIV_OPS_DIVU, 32'd20, 32'd3, 32'd6, 33);
      go_idle();

      // Asynchronous reset in cycle 15 of an operation.
      start_op(DIV_OPS_DIVU, 32'd7, 32'd2);
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      check("midrst_busy", XLEN'(div_busy_o), '0);
      check("midrst_valid", XLEN'(div_valid_o), '0);
      check("midrst_result", div_result_o, '0);
      div_req_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back: second request lands in the IDLE cycle right after DONE.
      do_op("b2b_divu_7_2", DIV_OPS_DIVU, 32'd7, 32'd2, 32'd3, 33);
      do_op("b2b_remu_7_2", DIV_OPS_REMU, 32'd7, 32'd2, 32'd1, 33);
      go_idle();
      repeat (3) @(negedge clk);
      check("result_hold", div_result_o, 32'd1);
      check("queue_empty", XLEN'(exp_q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exe_div_seq.md
# exe_div_seq

Iterative radix-2 divider sequencer attached to the execute stage. It accepts an RV32M divide or remainder operation from EXE, stalls the pipeline while it runs a restoring-division FSM for XLEN cycles, and returns the result with a one-cycle valid pulse. It owns the sign correction and the RISC-V divide-by-zero and overflow corner cases, so EXE only has to mux `div_result_o` into its result path.

## Interface
- `XLEN`, 32: operand and result width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `div_req_i`  in  1: EXE holds a divide-class instruction. Held high until the result is returned or the instruction is killed.
- `div_ops_i`  in  2: operation. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU (funct3[1:0]).
- `div_opr1_i`  in  XLEN: dividend (forwarded rs1).
- `div_opr2_i`  in  XLEN: divisor (forwarded rs2).
- `div_kill_i`  in  1: flush of the EXE instruction (branch, trap or fence redirect).
- `div_stall_o`  out  1: hold IF/ID/EXE this cycle.
- `div_valid_o`  out  1: one-cycle pulse; `div_result_o` is valid.
- `div_result_o`  out  XLEN: quotient or remainder.
- `div_busy_o`  out  1: FSM is not IDLE.

## Operation
- States:
  - IDLE: waits for a request.
  - CALC: iterates one quotient bit per cycle.
  - DONE: presents the result.
- IDLE with `div_req_i & ~div_kill_i`, the block captures:
  - the ops
  - |opr1| and |opr2| (absolute value only for DIV/REM; operands pass through for DIVU/REMU)
  - `neg_q` = sign1 ^ sign2 (signed ops only)
  - `neg_r` = sign1 (signed ops only)
  - counter = XLEN
  - remainder register = 0
  - quotient/dividend shift register = |opr1|
- Special cases are resolved in IDLE, and the FSM goes straight to DONE:
  - Divisor == 0: quotient = all ones, remainder = opr1 (unmodified).
  - DIV/REM with opr1 = 0x8000_0000 and opr2 = 0xFFFF_FFFF: quotient = opr1, remainder = 0.
  - All other requests go to CALC.
- Each CALC step:
  - rem' = {rem[XLEN-1:0], q[XLEN-1]}
  - diff = rem' − divisor, computed XLEN+1 bits wide
  - If diff ≥ 0: rem = diff and shift in 1. Otherwise: rem = rem' and shift in 0.
  - Counter decrements. When it reaches 1, go to DONE.
- Entering DONE: the final value is registered into `div_result_o`.
  - Quotient ops: negate if `neg_q`.
  - Remainder ops: negate if `neg_r`.
- DONE always goes to IDLE on the next cycle.
- `div_kill_i` in any state: go to IDLE next cycle, and no `div_valid_o` is produced. A kill arriving in DONE does not cancel the valid pulse already on the outputs that cycle; EXE discards it.
- A request arriving in the IDLE cycle straight after DONE is a new instruction and starts a new operation.

## Timing
- `div_stall_o` = `div_req_i & ~div_kill_i & (state != DONE)`. It is combinational and asserts in the request cycle itself.
- Normal operation:
  - Cycle 0: request accepted in IDLE.
  - Cycles 1..XLEN: CALC.
  - Cycle XLEN+1: DONE, with `div_valid_o` = 1 and stall = 0.
  - Latency is 33 cycles for XLEN = 32.
- Special cases: DONE in cycle 1, latency 1.
- `div_valid_o` is high only in DONE and is registered.
- `div_result_o` holds its value until the next DONE.
- Reset values: state = IDLE, `div_valid_o` = 0, `div_result_o` = 0, `div_busy_o` = 0, counter = 0.
  - During reset, `div_stall_o` = `div_req_i & ~div_kill_i`; EXE keeps `div_req_i` low under reset.
- Reset mid-operation: all state is cleared immediately, with no valid pulse.
- Operands are sampled only in IDLE. Changes to the operand inputs during CALC are ignored.

## Structure
- Shared defines package:
  - `type_div_ops_e` (DIV_OPS_DIV, DIV_OPS_DIVU, DIV_OPS_REM, DIV_OPS_REMU)
  - `type_div_state_e` (DIV_IDLE, DIV_CALC, DIV_DONE)
  - an `exe2div`/`div2exe` struct pair that bundles the ports above
- Single module with no sub-modules. The FSM, the counter (`$clog2(XLEN)+1` bits) and the shift/subtract datapath are all local.

## Test plan
- DIVU 100 / 7: stall high for cycles 0..32, `div_valid_o` in cycle 33, result = 14. REMU of the same operands gives 2.
- DIV −100 / 7: result = 0xFFFF_FFF2 (−14). REM of the same operands gives 0xFFFF_FFFE (−2).
- DIVU 5 / 0: result 0xFFFF_FFFF in cycle 1. REMU 5 / 0 gives 5. DIV −3 / 0 gives 0xFFFF_FFFF. REM −3 / 0 gives 0xFFFF_FFFD.
- DIV 0x8000_0000 / 0xFFFF_FFFF: result 0x8000_0000 in cycle 1. REM of the same operands gives 0.
- Start DIVU 1000 / 3 and assert `div_kill_i` in cycle 10: stall drops in cycle 10, state is IDLE in cycle 11, and `div_valid_o` never pulses. A following DIVU 20 / 3 returns 6 after 33 cycles.
- Assert `rst` in cycle 15 of an operation: state is IDLE, `div_valid_o` = 0 and `div_result_o` = 0 immediately. Back-to-back DIVU 7/2 then REMU 7/2 return 3 then 1, each after 33 cycles.
